top2_frame_sched: RTL and testbench

Round-robin scheduler that shares one top-two tracker datapath between `NUM_REQ` streaming requesters. It grants the tracker to one requester for a whole frame and clears it at frame start. It streams the frame's samples through the tracker, then returns the frame's largest and second-largest values, tagged with the requester id, over a valid/ready result port. It sits between the sample producers and the statistics consumer, replacing one tracker instance per stream.

---
 rtl/top2_frame_sched_pkg.sv | 55 +++++
 rtl/top2_frame_sched_if.sv | 43 ++++
 rtl/top2_tracker.sv | 60 ++++++
 rtl/top2_frame_sched.sv | 130 +++++++++++++
 tb/tb_top2_frame_sched.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/top2_frame_sched_pkg.sv
// -----------------------------------------------------------------------------
// top2_pkg
// Shared types and helpers for the top-two frame scheduler.
//   sched_state_t : scheduler FSM states (IDLE, STREAM, RESULT)
//   id_width()    : requester-id width for a given requester count
//   rr_next()     : round-robin successor of an index
//   rr_pick()     : first valid requester at or after a start index
// -----------------------------------------------------------------------------
package top2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        RESULT = 2'd2
    } sched_state_t;

    // Upper bound on requesters the pick helper can scan; valid vectors are
    // zero-extended to this width before being handed to rr_pick().
    localparam int MAX_REQ = 32;
    localparam int DEFAULT_NUM_REQ = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_WIDTH = id_width(DEFAULT_NUM_REQ);

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    // Walks offsets from the highest down to zero so that the smallest
    // offset from 'start' that has a valid request is the one left in 'pick'.
    // Both start and the offset are below n, so a single subtraction is
    // enough to wrap the index.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                   input int start, input int n);
        int pick;
        int idx;
        pick = start;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = start + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[4:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/top2_frame_sched_if.sv
// -----------------------------------------------------------------------------
// top2_frame_sched_if
// Bundles the requester sample bus and the result bus of the scheduler.
//   req_valid/req_data/req_last : per-requester sample stream (into scheduler)
//   req_ready                   : one-hot-or-zero ready back to requesters
//   res_valid/res_ready         : result handshake
//   res_largest/res_second      : frame maximum and second largest
//   res_id/res_count            : owning requester and saturating beat count
//   busy                        : scheduler is not idle
// Modports: slave = scheduler side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface top2_frame_sched_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 16
);
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          res_valid;
    logic                          res_ready;
    logic [DATA_WIDTH-1:0]         res_largest;
    logic [DATA_WIDTH-1:0]         res_second;
    logic [ID_WIDTH-1:0]           res_id;
    logic [COUNT_WIDTH-1:0]        res_count;
    logic                          busy;

    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_largest, res_second, res_id,
               res_count, busy
    );

    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_largest, res_second, res_id,
               res_count, busy
    );

endinterface

// File: rtl/top2_tracker.sv
// -----------------------------------------------------------------------------
// top2_tracker
// Tracks the largest and second-largest unsigned values of a sample stream
// and counts accepted samples with a saturating counter.
//   clk, reset : clock and asynchronous active-high reset
//   clear      : synchronous clear of all tracked state (frame start)
//   en         : din is an accepted sample this cycle
//   din        : sample value
//   largest    : running maximum
//   second     : running second largest (equals largest on duplicate maxima)
//   count      : number of samples seen, sticks at all-ones
// -----------------------------------------------------------------------------
module top2_tracker #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   en,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  largest,
    output logic [DATA_WIDTH-1:0]  second,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [DATA_WIDTH-1:0]  r_largest;
    logic [DATA_WIDTH-1:0]  r_second;
    logic [COUNT_WIDTH-1:0] r_count;

    // A new maximum pushes the old maximum down into second place; a value
    // equal to the maximum but above second only replaces second, which is
    // how duplicate maxima end up with second == largest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_largest <= '0;
            r_second  <= '0;
            r_count   <= '0;
        end else if (clear) begin
            r_largest <= '0;
            r_second  <= '0;
            r_count   <= '0;
        end else if (en) begin
            if (din > r_largest && din > r_second) begin
                r_second  <= r_largest;
                r_largest <= din;
            end else if (din > r_second) begin
                r_second <= din;
            end
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign largest = r_largest;
    assign second  = r_second;
    assign count   = r_count;

endmodule

// File: rtl/top2_frame_sched.sv
// -----------------------------------------------------------------------------
// top2_frame_sched
// Round-robin scheduler sharing one top-two tracker between NUM_REQ
// requesters, one whole frame at a time.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : top2_frame_sched_if.slave carrying the requester streams,
//                the valid/ready result port and the busy flag
// The tracker registers double as the result registers: they are frozen
// while in RESULT and only cleared at the next grant, so res_* stay stable
// until the consumer takes them.
// -----------------------------------------------------------------------------
module top2_frame_sched
    import top2_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 16
) (
    input logic              clk,
    input logic              reset,
    top2_frame_sched_if.slave bus
);

    localparam int ID_W = id_width(NUM_REQ);

    sched_state_t            r_state;
    sched_state_t            w_nextState;
    logic [ID_W-1:0]         r_grant;
    logic [ID_W-1:0]         r_ptr;
    logic [MAX_REQ-1:0]      w_validPad;
    logic [ID_W-1:0]         w_pick;
    logic                    w_anyValid;
    logic                    w_beat;
    logic                    w_clear;
    logic                    w_en;
    logic [DATA_WIDTH-1:0]   w_reqData [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_din;
    logic [DATA_WIDTH-1:0]   w_largest;
    logic [DATA_WIDTH-1:0]   w_second;
    logic [COUNT_WIDTH-1:0]  w_count;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_reqData[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // r_ptr holds the index that gets first priority next time, so a reset
    // value of zero gives requester 0 priority.
    assign w_validPad = MAX_REQ'(bus.req_valid);
    assign w_anyValid = |bus.req_valid;
    assign w_pick     = ID_W'(rr_pick(w_validPad, int'(r_ptr), NUM_REQ));
    assign w_din      = w_reqData[r_grant];
    assign w_beat     = (r_state == STREAM) && bus.req_valid[r_grant];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant is captured on the edge that leaves IDLE; the pointer advances
    // past the owner only once its result has been handed off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            if (r_state == IDLE && w_anyValid) begin
                r_grant <= w_pick;
            end
            if (r_state == RESULT && bus.res_ready) begin
                r_ptr <= ID_W'(rr_next(int'(r_grant), NUM_REQ));
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyValid) w_nextState = STREAM;
            STREAM:  if (w_beat && bus.req_last[r_grant]) w_nextState = RESULT;
            RESULT:  if (bus.res_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.res_valid = 1'b0;
        bus.busy      = (r_state != IDLE);
        w_clear       = 1'b0;
        w_en          = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = w_anyValid;
            end
            STREAM: begin
                bus.req_ready[r_grant] = 1'b1;
                w_en = w_beat;
            end
            RESULT: begin
                bus.res_valid = 1'b1;
            end
            default: begin
                bus.req_ready = '0;
            end
        endcase
    end

    top2_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_tracker (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .en     (w_en),
        .din    (w_din),
        .largest(w_largest),
        .second (w_second),
        .count  (w_count)
    );

    assign bus.res_largest = w_largest;
    assign bus.res_second  = w_second;
    assign bus.res_count   = w_count;
    assign bus.res_id      = r_grant;

endmodule

// File: tb/tb_top2_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_top2_frame_sched
// Directed-vector bench for top2_frame_sched: reset values, a five-beat
// frame with duplicate maxima, a single-beat frame, round-robin rotation,
// result backpressure, mid-frame stall and reset in the middle of a frame.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_top2_frame_sched;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    top2_frame_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .COUNT_WIDTH(CW)) bus ();

    top2_frame_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .COUNT_WIDTH(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one requester's valid/data/last.
    task automatic setBeat(input int r, input logic v, input logic [DW-1:0] d, input logic l);
        bus.req_valid[r]           = v;
        bus.req_data[r*DW +: DW]   = d;
        bus.req_last[r]            = l;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        checks++; if (bus.res_largest !== 32'd0) begin errors++; $display("[TB] FAIL reset_largest: got %0d expected 0", bus.res_largest); end
        checks++; if (bus.res_second !== 32'd0) begin errors++; $display("[TB] FAIL reset_second: got %0d expected 0", bus.res_second); end
        checks++; if (bus.res_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.res_count); end
        checks++; if (bus.res_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_id: got %0d expected 0", bus.res_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [DW-1:0] v [5] = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd7};
        setBeat(0, 1'b1, v[0], 1'b0);
        tick();
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant: got %b expected 0001", bus.req_ready); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", bus.busy); end
        for (int i = 0; i < 5; i++) begin
            setBeat(0, 1'b1, v[i], (i == 4));
            if (i == 4) begin
                checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %b expected 0", bus.res_valid); end
            end
            tick();
        end
        setBeat(0, 1'b0, '0, 1'b0);
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_res_valid: got %b expected 1", bus.res_valid); end
        checks++; if (bus.res_largest !== 32'd9) begin errors++; $display("[TB] FAIL single_largest: got %0d expected 9", bus.res_largest); end
        checks++; if (bus.res_second !== 32'd9) begin errors++; $display("[TB] FAIL single_second: got %0d expected 9", bus.res_second); end
        checks++; if (bus.res_count !== 16'd5) begin errors++; $display("[TB] FAIL single_count: got %0d expected 5", bus.res_count); end
        checks++; if (bus.res_id !== 2'd0) begin errors++; $display("[TB] FAIL single_id: got %0d expected 0", bus.res_id); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL single_ready_in_result: got %b expected 0000", bus.req_ready); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_after_hs_valid: got %b expected 0", bus.res_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_after_hs_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_single_beat();
        setBeat(2, 1'b1, 32'd42, 1'b1);
        tick();
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL beat1_grant: got %b expected 0100", bus.req_ready); end
        tick();
        setBeat(2, 1'b0, '0, 1'b0);
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL beat1_valid: got %b expected 1", bus.res_valid); end
        checks++; if (bus.res_largest !== 32'd42) begin errors++; $display("[TB] FAIL beat1_largest: got %0d expected 42", bus.res_largest); end
        checks++; if (bus.res_second !== 32'd0) begin errors++; $display("[TB] FAIL beat1_second: got %0d expected 0", bus.res_second); end
        checks++; if (bus.res_count !== 16'd1) begin errors++; $display("[TB] FAIL beat1_count: got %0d expected 1", bus.res_count); end
        checks++; if (bus.res_id !== 2'd2) begin errors++; $display("[TB] FAIL beat1_id: got %0d expected 2", bus.res_id); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int expId;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int r = 0; r < NR; r++) begin
            setBeat(r, 1'b1, DW'(10 + r), 1'b1);
        end
        bus.res_ready = 1'b1;
        expId = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++; if ($countones(bus.req_ready) > 1) begin errors++; $display("[TB] FAIL rr_onehot: got %b expected at most one bit", bus.req_ready); end
            if (k % 3 == 1) begin
                checks++; if (bus.req_ready !== 4'(1 << expId)) begin errors++; $display("[TB] FAIL rr_grant: got %b expected %b", bus.req_ready, 4'(1 << expId)); end
            end else if (k % 3 == 2) begin
                checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(expId)) begin errors++; $display("[TB] FAIL rr_result: got valid=%b id=%0d expected valid=1 id=%0d", bus.res_valid, bus.res_id, expId); end
                checks++; if (bus.res_largest !== DW'(10 + expId)) begin errors++; $display("[TB] FAIL rr_largest: got %0d expected %0d", bus.res_largest, 10 + expId); end
                expId = (expId + 1) % NR;
            end else begin
                checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle: got valid=%b busy=%b expected 0 0", bus.res_valid, bus.busy); end
            end
        end
        for (int r = 0; r < NR; r++) begin
            setBeat(r, 1'b0, '0, 1'b0);
        end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        setBeat(3, 1'b1, 32'd20, 1'b0);
        tick();
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL bp_grant: got %b expected 1000", bus.req_ready); end
        tick();
        setBeat(3, 1'b1, 32'd30, 1'b1);
        tick();
        setBeat(3, 1'b0, '0, 1'b0);
        setBeat(0, 1'b1, 32'd5, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.res_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_hold: got valid=%b ready=%b expected 1 0000", bus.res_valid, bus.req_ready); end
            checks++; if (bus.res_largest !== 32'd30 || bus.res_second !== 32'd20) begin errors++; $display("[TB] FAIL bp_values: got %0d/%0d expected 30/20", bus.res_largest, bus.res_second); end
            checks++; if (bus.res_count !== 16'd2 || bus.res_id !== 2'd3) begin errors++; $display("[TB] FAIL bp_tag: got count=%0d id=%0d expected 2 3", bus.res_count, bus.res_id); end
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got valid=%b busy=%b expected 0 0", bus.res_valid, bus.busy); end
        tick();
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL bp_next_grant: got %b expected 0001", bus.req_ready); end
        tick();
        setBeat(0, 1'b0, '0, 1'b0);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_largest !== 32'd5) begin errors++; $display("[TB] FAIL bp_next_result: got valid=%b id=%0d largest=%0d expected 1 0 5", bus.res_valid, bus.res_id, bus.res_largest); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_stall();
        setBeat(1, 1'b1, 32'd1, 1'b0);
        tick();
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL stall_grant: got %b expected 0010", bus.req_ready); end
        tick();
        setBeat(1, 1'b1, 32'd100, 1'b0);
        tick();
        setBeat(1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.req_ready !== 4'b0010 || bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold: got ready=%b valid=%b busy=%b expected 0010 0 1", bus.req_ready, bus.res_valid, bus.busy); end
        end
        setBeat(1, 1'b1, 32'd50, 1'b1);
        tick();
        setBeat(1, 1'b0, '0, 1'b0);
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid: got %b expected 1", bus.res_valid); end
        checks++; if (bus.res_largest !== 32'd100) begin errors++; $display("[TB] FAIL stall_largest: got %0d expected 100", bus.res_largest); end
        checks++; if (bus.res_second !== 32'd50) begin errors++; $display("[TB] FAIL stall_second: got %0d expected 50", bus.res_second); end
        checks++; if (bus.res_count !== 16'd3 || bus.res_id !== 2'd1) begin errors++; $display("[TB] FAIL stall_tag: got count=%0d id=%0d expected 3 1", bus.res_count, bus.res_id); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        setBeat(2, 1'b1, 32'd77, 1'b0);
        tick();
        tick();
        setBeat(2, 1'b1, 32'd88, 1'b0);
        tick();
        checks++; if (bus.res_count !== 16'd2 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre: got count=%0d busy=%b expected 2 1", bus.res_count, bus.busy); end
        reset = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ctrl: got ready=%b busy=%b valid=%b expected 0000 0 0", bus.req_ready, bus.busy, bus.res_valid); end
        checks++; if (bus.res_largest !== 32'd0 || bus.res_count !== 16'd0 || bus.res_id !== 2'd0) begin errors++; $display("[TB] FAIL midrst_data: got largest=%0d count=%0d id=%0d expected 0 0 0", bus.res_largest, bus.res_count, bus.res_id); end
        setBeat(2, 1'b0, '0, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_result: got %b expected 0", bus.res_valid); end
        end
        setBeat(0, 1'b1, 32'd8, 1'b0);
        tick();
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_grant: got %b expected 0001", bus.req_ready); end
        tick();
        setBeat(0, 1'b1, 32'd4, 1'b1);
        tick();
        setBeat(0, 1'b0, '0, 1'b0);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_largest !== 32'd8 || bus.res_second !== 32'd4) begin errors++; $display("[TB] FAIL midrst_result: got valid=%b %0d/%0d expected 1 8/4", bus.res_valid, bus.res_largest, bus.res_second); end
        checks++; if (bus.res_count !== 16'd2 || bus.res_id !== 2'd0) begin errors++; $display("[TB] FAIL midrst_tag: got count=%0d id=%0d expected 2 0", bus.res_count, bus.res_id); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_single_beat();
        test_round_robin();
        test_backpressure();
        test_stall();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guards against a hung run; the directed sequence needs well under this.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
